conversor_bcd_produto: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the shift-add multiplier. It captures `Produto` on the multiplier's `Done` pulse and converts it with the shift-add-3 (double-dabble) algorithm, one bit per clock. It presents hundreds/tens/units digits for a display stage. A one-entry pending buffer absorbs a second product that arrives during a conversion.

---
 rtl/conversor_bcd_pkg.sv | 14 +
 rtl/ajuste_bcd.sv | 12 +
 rtl/conversor_bcd_produto.sv | 151 +++++++++++++++
 tb/tb_conversor_bcd_produto.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/conversor_bcd_pkg.sv
// Shared types and defaults for the product-to-BCD converter.
package conversor_bcd_pkg;

  localparam int unsigned LARGURA_PADRAO = 8;
  localparam int unsigned DIGITOS_PADRAO = 3;

  typedef logic [3:0] digito_bcd_t;

  typedef enum logic [0:0] {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } estado_t;

endpackage

// File: rtl/ajuste_bcd.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module ajuste_bcd (
  input  logic [3:0] digito,
  output logic [3:0] ajustado_c
);

  always_comb begin
    ajustado_c = digito;
    if (digito >= 4'd5) ajustado_c = digito + 4'd3;
  end

endmodule

// File: rtl/conversor_bcd_produto.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) fed by the
// multiplier's Done pulse, with a one-entry pending buffer for back-to-back products.
module conversor_bcd_produto
  import conversor_bcd_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PADRAO,
  parameter int unsigned DIGITOS = DIGITOS_PADRAO
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Done,
  input  logic [LARGURA-1:0] Produto,
  output logic [3:0]         Centena,
  output logic [3:0]         Dezena,
  output logic [3:0]         Unidade,
  output logic               Valido,
  output logic               Ocupado,
  output logic               Perdido
);

  localparam int unsigned BCD_W = 4 * DIGITOS;
  localparam int unsigned CW    = $clog2(LARGURA + 1);

  estado_t            estado_q, estado_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LARGURA-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [LARGURA-1:0] pend_val_q, pend_val_d;
  logic               pend_cheio_q, pend_cheio_d;
  digito_bcd_t        centena_q, centena_d;
  digito_bcd_t        dezena_q, dezena_d;
  digito_bcd_t        unidade_q, unidade_d;
  logic               valido_q, valido_d;
  logic               ocupado_q, ocupado_d;
  logic               perdido_q, perdido_d;

  logic [BCD_W-1:0]   bcd_ajustado_c;
  logic [BCD_W-1:0]   bcd_desl_c;
  logic [LARGURA-1:0] bin_desl_c;
  logic               ultimo_c;
  logic               unused_msb_c;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .digito     (bcd_q[4*g +: 4]),
      .ajustado_c (bcd_ajustado_c[4*g +: 4])
    );
  end

  // One double-dabble step: corrected BCD and binary shift left together.
  assign bcd_desl_c   = {bcd_ajustado_c[BCD_W-2:0], bin_q[LARGURA-1]};
  assign bin_desl_c   = {bin_q[LARGURA-2:0], 1'b0};
  assign unused_msb_c = bcd_ajustado_c[BCD_W-1];
  assign ultimo_c     = (estado_q == CONVERTE) && (cnt_q == CW'(1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      estado_q     <= OCIOSO;
      cnt_q        <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      pend_val_q   <= '0;
      pend_cheio_q <= 1'b0;
      centena_q    <= '0;
      dezena_q     <= '0;
      unidade_q    <= '0;
      valido_q     <= 1'b0;
      ocupado_q    <= 1'b0;
      perdido_q    <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      pend_val_q   <= pend_val_d;
      pend_cheio_q <= pend_cheio_d;
      centena_q    <= centena_d;
      dezena_q     <= dezena_d;
      unidade_q    <= unidade_d;
      valido_q     <= valido_d;
      ocupado_q    <= ocupado_d;
      perdido_q    <= perdido_d;
    end
  end

  // Stay converting after the final bit whenever another product is waiting.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO:   if (Done) estado_d = CONVERTE;
      CONVERTE: if (ultimo_c && !pend_cheio_q && !Done) estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    pend_val_d   = pend_val_q;
    pend_cheio_d = pend_cheio_q;
    centena_d    = centena_q;
    dezena_d     = dezena_q;
    unidade_d    = unidade_q;
    valido_d     = 1'b0;
    perdido_d    = perdido_q;
    ocupado_d    = (estado_d == CONVERTE);

    if (estado_q == OCIOSO) begin
      if (Done) begin
        bin_d = Produto;
        bcd_d = '0;
        cnt_d = CW'(LARGURA);
      end
    end else begin
      bin_d = bin_desl_c;
      bcd_d = bcd_desl_c;
      cnt_d = cnt_q - CW'(1);
      if (ultimo_c) begin
        unidade_d = bcd_desl_c[3:0];
        dezena_d  = bcd_desl_c[7:4];
        centena_d = bcd_desl_c[11:8];
        valido_d  = 1'b1;
        // The waiting product has priority; a simultaneous Done refills the buffer.
        if (pend_cheio_q) begin
          bin_d = pend_val_q;
          bcd_d = '0;
          cnt_d = CW'(LARGURA);
          if (Done) pend_val_d = Produto;
          else      pend_cheio_d = 1'b0;
        end else if (Done) begin
          bin_d = Produto;
          bcd_d = '0;
          cnt_d = CW'(LARGURA);
        end
      end else if (Done) begin
        pend_val_d   = Produto;
        pend_cheio_d = 1'b1;
        if (pend_cheio_q) perdido_d = 1'b1;
      end
    end
  end

  assign Centena = centena_q;
  assign Dezena  = dezena_q;
  assign Unidade = unidade_q;
  assign Valido  = valido_q;
  assign Ocupado = ocupado_q;
  assign Perdido = perdido_q;

endmodule

// File: tb/tb_conversor_bcd_produto.sv
// Directed bench for conversor_bcd_produto with hand-computed BCD results.
module tb_conversor_bcd_produto;

  logic       Clk;
  logic       Rst_n;
  logic       Done;
  logic [7:0] Produto;
  logic [3:0] Centena, Dezena, Unidade;
  logic       Valido, Ocupado, Perdido;

  int n_comp = 0;
  int n_erro = 0;

  conversor_bcd_produto dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Done    (Done),
    .Produto (Produto),
    .Centena (Centena),
    .Dezena  (Dezena),
    .Unidade (Unidade),
    .Valido  (Valido),
    .Ocupado (Ocupado),
    .Perdido (Perdido)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_comp++;
    if (obs !== esp) begin
      n_erro++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic verifica_digitos(input string tag, input logic [3:0] c, input logic [3:0] d,
                                  input logic [3:0] u);
    verifica({tag, "_centena"}, Centena, c);
    verifica({tag, "_dezena"},  Dezena,  d);
    verifica({tag, "_unidade"}, Unidade, u);
  endtask

  task automatic converte(input logic [7:0] p, input logic [3:0] c, input logic [3:0] d,
                          input logic [3:0] u, input string tag);
    int lat;
    int ocup;
    Done = 1'b1; Produto = p;
    tick();
    Done = 1'b0;
    lat = 0; ocup = 0;
    while (!Valido && lat < 20) begin
      if (Ocupado) ocup++;
      tick();
      lat++;
    end
    verifica({tag, "_latencia"}, lat, 8);
    verifica({tag, "_ocupado_ciclos"}, ocup, 8);
    verifica_digitos(tag, c, d, u);
    verifica({tag, "_ocupado_fim"}, Ocupado, 0);
    tick();
    verifica({tag, "_valido_pulso"}, Valido, 0);
    verifica_digitos({tag, "_retem"}, c, d, u);
  endtask

  initial begin
    int v1, v2, vis;
    logic ocup_caiu;
    logic [3:0] c1, d1, u1, c2, d2, u2;

    Rst_n = 1'b0; Done = 1'b0; Produto = '0;
    tick(); tick();
    verifica("rst_centena", Centena, 0);
    verifica("rst_dezena",  Dezena,  0);
    verifica("rst_unidade", Unidade, 0);
    verifica("rst_valido",  Valido,  0);
    verifica("rst_ocupado", Ocupado, 0);
    verifica("rst_perdido", Perdido, 0);
    Rst_n = 1'b1;
    tick();

    converte(8'h8F, 4'd1, 4'd4, 4'd3, "p143");
    converte(8'd225, 4'd2, 4'd2, 4'd5, "p225");
    converte(8'd0,   4'd0, 4'd0, 4'd0, "p0");
    converte(8'd255, 4'd2, 4'd5, 4'd5, "p255");
    tick();

    // Second product three edges into a conversion waits in the buffer.
    Done = 1'b1; Produto = 8'd143;
    tick();
    Done = 1'b0;
    v1 = -1; v2 = -1; ocup_caiu = 1'b0;
    c1 = '0; d1 = '0; u1 = '0; c2 = '0; d2 = '0; u2 = '0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 3) begin Done = 1'b1; Produto = 8'd225; end
      tick();
      Done = 1'b0;
      if (v2 < 0 && !Ocupado && !(Valido && v1 >= 0)) ocup_caiu = 1'b1;
      if (Valido) begin
        if (v1 < 0) begin v1 = k; c1 = Centena; d1 = Dezena; u1 = Unidade; end
        else if (v2 < 0) begin v2 = k; c2 = Centena; d2 = Dezena; u2 = Unidade; end
      end
    end
    verifica("pend_v1_borda", v1, 8);
    verifica("pend_v2_borda", v2, 16);
    verifica("pend_r1", {c1, d1, u1}, 12'h143);
    verifica("pend_r2", {c2, d2, u2}, 12'h225);
    verifica("pend_ocupado_caiu", ocup_caiu, 0);
    verifica("pend_perdido", Perdido, 0);

    // Two extra products during one conversion: the newer survives, overrun flagged.
    Done = 1'b1; Produto = 8'd143;
    tick();
    Done = 1'b0;
    v1 = -1; v2 = -1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 2) begin Done = 1'b1; Produto = 8'd10; end
      if (k == 4) begin Done = 1'b1; Produto = 8'd20; end
      tick();
      Done = 1'b0;
      if (Valido) begin
        if (v1 < 0) begin v1 = k; c1 = Centena; d1 = Dezena; u1 = Unidade; end
        else if (v2 < 0) begin v2 = k; c2 = Centena; d2 = Dezena; u2 = Unidade; end
      end
    end
    verifica("ovr_r1", {c1, d1, u1}, 12'h143);
    verifica("ovr_v2_borda", v2, 16);
    verifica("ovr_r2", {c2, d2, u2}, 12'h020);
    verifica("ovr_perdido", Perdido, 1);
    converte(8'd37, 4'd0, 4'd3, 4'd7, "p37");
    verifica("ovr_perdido_retido", Perdido, 1);

    // Reset at the fourth edge of a conversion aborts it.
    Done = 1'b1; Produto = 8'd200;
    tick();
    Done = 1'b0;
    tick(); tick(); tick();
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    verifica_digitos("rstm", 4'd0, 4'd0, 4'd0);
    verifica("rstm_ocupado", Ocupado, 0);
    verifica("rstm_perdido", Perdido, 0);
    vis = 0;
    for (int k = 0; k < 12; k++) begin
      if (Valido) vis++;
      tick();
    end
    verifica("rstm_sem_valido", vis, 0);
    converte(8'd99, 4'd0, 4'd9, 4'd9, "p99");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
    $finish;
  end

endmodule
